// File: rtl/basic_computer_pkg.sv
// ---------------------------------------------------------------------------
// basic_computer_pkg
// Shared constants and types for the basic-computer fetch datapath:
//   - default address/data widths
//   - instruction field positions (opcode and indirect bit) for the default DW
//   - common-bus source select encoding and its priority encoder
// ---------------------------------------------------------------------------
package basic_computer_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;

  // Field positions within a DW_DEF-bit instruction word.
  localparam int I_BIT = DW_DEF - 1;
  localparam int OP_HI = DW_DEF - 2;
  localparam int OP_LO = DW_DEF - 4;

  typedef enum logic [1:0] {
    BUS_NONE = 2'd0,
    BUS_PC   = 2'd1,
    BUS_IR   = 2'd2,
    BUS_DR   = 2'd3
  } bus_sel_e;

  // Memory data wins over IR, IR wins over PC.
  function automatic bus_sel_e bus_sel(input logic x2, input logic x5, input logic x7);
    if (x7) return BUS_DR;
    if (x5) return BUS_IR;
    if (x2) return BUS_PC;
    return BUS_NONE;
  endfunction

endpackage

// File: rtl/fetch_mem.sv
// ---------------------------------------------------------------------------
// fetch_mem
// Main memory array (2**AW words of DW bits) with a synchronous write port
// and a read port registered into the data register on a read enable.
// The array itself is not reset; only the read register is.
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset (clears read register only)
//   we_i     write strobe: M[waddr_i] <= wdata_i
//   waddr_i  write address
//   wdata_i  write data
//   re_i     read enable: rdata_o <= M[raddr_i]
//   raddr_i  read address
//   rdata_o  registered read data (holds when re_i is low)
// ---------------------------------------------------------------------------
module fetch_mem #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Sampling the array with a non-blocking read gives read-before-write on
  // a same-address collision.
  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fetch_datapath.sv
// ---------------------------------------------------------------------------
// fetch_datapath
// Register-transfer datapath driven by the control unit's fetch/decode
// strobes. Holds PC, AR, IR, DR (inside fetch_mem), the I flip-flop and a
// registered common bus. Returns opcode and the indirect bit to the control
// unit. All strobes act on pre-edge register values.
// Optional feature macro: FETCH_BUS_CHECK_EN adds a sticky bus_err output.
// Ports:
//   clk, rst           clock / synchronous active-high reset
//   inrPC              PC <= PC + 1 (wraps modulo 2**AW)
//   Read               DR <= M[AR]
//   ldAR, ldIR, ldI    load AR / IR / I from bus_q
//   x2, x5, x7         bus source select: PC / IR / DR (x7 > x5 > x2)
//   prog_we/addr/data  program-load write port (ignored during rst)
//   op, Iout           opcode field of IR, I flip-flop
//   pc_o, ar_o, ir_o   debug views of PC, AR, IR
//   bus_err            (FETCH_BUS_CHECK_EN only) sticky select/ordering error
// ---------------------------------------------------------------------------
module fetch_datapath
  import basic_computer_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter int            DW       = DW_DEF,
  parameter logic [AW-1:0] PC_RESET = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inrPC,
  input  logic          Read,
  input  logic          ldAR,
  input  logic          ldIR,
  input  logic          ldI,
  input  logic          x2,
  input  logic          x5,
  input  logic          x7,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [2:0]    op,
  output logic          Iout,
  output logic [AW-1:0] pc_o,
  output logic [AW-1:0] ar_o,
  output logic [DW-1:0] ir_o
`ifdef FETCH_BUS_CHECK_EN
  ,
  output logic          bus_err
`endif
);

  // Field positions track DW, keeping the same offsets from the MSB as the
  // default word layout in the package. DW must be at least AW+4.
  localparam int IBit = DW - 1;
  localparam int OpHi = IBit - (I_BIT - OP_HI);
  localparam int OpLo = IBit - (I_BIT - OP_LO);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] ar_q, ar_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] bus_q, bus_d;
  logic          i_q, i_d;
  logic [DW-1:0] dr;
  bus_sel_e      sel;

  assign sel = bus_sel(x2, x5, x7);

  fetch_mem #(
    .AW(AW),
    .DW(DW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (prog_we & ~rst),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .re_i    (Read),
    .raddr_i (ar_q),
    .rdata_o (dr)
  );

  always_comb begin
    bus_d = bus_q;
    case (sel)
      BUS_PC:  bus_d = {{(DW-AW){1'b0}}, pc_q};
      BUS_IR:  bus_d = ir_q;
      BUS_DR:  bus_d = dr;
      default: bus_d = bus_q;
    endcase
    pc_d = inrPC ? pc_q + AW'(1)     : pc_q;
    ar_d = ldAR  ? bus_q[AW-1:0]     : ar_q;
    ir_d = ldIR  ? bus_q             : ir_q;
    i_d  = ldI   ? bus_q[IBit]       : i_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= PC_RESET;
      ar_q  <= '0;
      ir_q  <= '0;
      bus_q <= '0;
      i_q   <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ar_q  <= ar_d;
      ir_q  <= ir_d;
      bus_q <= bus_d;
      i_q   <= i_d;
    end
  end

  assign op   = ir_q[OpHi:OpLo];
  assign Iout = i_q;
  assign pc_o = pc_q;
  assign ar_o = ar_q;
  assign ir_o = ir_q;

`ifdef FETCH_BUS_CHECK_EN
  logic bus_wr_q, bus_wr_d;
  logic bus_err_q, bus_err_d;
  logic multi_sel;

  assign multi_sel = (x2 & x5) | (x2 & x7) | (x5 & x7);

  // bus_wr_q remembers whether bus_q has been loaded since reset, so that
  // an IR load from the never-written bus can be flagged.
  always_comb begin
    bus_wr_d  = bus_wr_q | x2 | x5 | x7;
    bus_err_d = bus_err_q | multi_sel | (ldIR & ~bus_wr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_wr_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      bus_wr_q  <= bus_wr_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`endif

endmodule

// File: tb/tb_fetch_datapath.sv
module tb_fetch_datapath;

  localparam int AW = 12;
  localparam int DW = 16;

  localparam int M_INR  = 1;
  localparam int M_RD   = 2;
  localparam int M_LDAR = 4;
  localparam int M_LDIR = 8;
  localparam int M_LDI  = 16;
  localparam int M_X2   = 32;
  localparam int M_X5   = 64;
  localparam int M_X7   = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          inrPC, Read, ldAR, ldIR, ldI, x2, x5, x7;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic [2:0]    op;
  logic          Iout;
  logic [AW-1:0] pc_o, ar_o;
  logic [DW-1:0] ir_o;
`ifdef FETCH_BUS_CHECK_EN
  logic          bus_err;
`endif

  always #5 clk = ~clk;

  fetch_datapath #(
    .AW(AW),
    .DW(DW),
    .PC_RESET(12'h010)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inrPC     (inrPC),
    .Read      (Read),
    .ldAR      (ldAR),
    .ldIR      (ldIR),
    .ldI       (ldI),
    .x2        (x2),
    .x5        (x5),
    .x7        (x7),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .op        (op),
    .Iout      (Iout),
    .pc_o      (pc_o),
    .ar_o      (ar_o),
    .ir_o      (ir_o)
`ifdef FETCH_BUS_CHECK_EN
    ,
    .bus_err   (bus_err)
`endif
  );

  typedef enum int {SIG_PC, SIG_AR, SIG_IR, SIG_OP, SIG_I, SIG_ERR} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] observe(input sig_e s);
    case (s)
      SIG_PC:  return {4'h0, pc_o};
      SIG_AR:  return {4'h0, ar_o};
      SIG_IR:  return ir_o;
      SIG_OP:  return {13'h0, op};
      SIG_I:   return {15'h0, Iout};
`ifdef FETCH_BUS_CHECK_EN
      SIG_ERR: return {15'h0, bus_err};
`endif
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic expect_val(input string tag, input sig_e s, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic expect_err(input string tag, input logic v);
`ifdef FETCH_BUS_CHECK_EN
    expect_val(tag, SIG_ERR, {15'h0, v});
`endif
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sig), e.val);
    end
  endtask

  task automatic clr();
    inrPC = 0; Read = 0; ldAR = 0; ldIR = 0; ldI = 0;
    x2 = 0; x5 = 0; x7 = 0; prog_we = 0;
  endtask

  // One clock with the given strobe mask; outputs are sampled 1 ns after
  // the edge by the following drain().
  task automatic strobe(input int m);
    inrPC = (m & M_INR)  != 0;
    Read  = (m & M_RD)   != 0;
    ldAR  = (m & M_LDAR) != 0;
    ldIR  = (m & M_LDIR) != 0;
    ldI   = (m & M_LDI)  != 0;
    x2    = (m & M_X2)   != 0;
    x5    = (m & M_X5)   != 0;
    x7    = (m & M_X7)   != 0;
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic prog(input logic [AW-1:0] a, input logic [DW-1:0] d);
    prog_we   = 1;
    prog_addr = a;
    prog_data = d;
    @(posedge clk);
    #1;
    prog_we = 0;
  endtask

  task automatic fetch_t0_t4();
    strobe(M_X2);
    strobe(M_LDAR);
    strobe(M_RD);
    strobe(M_X7);
    strobe(M_LDIR | M_INR);
  endtask

  task automatic fetch_t5_t6();
    strobe(M_X5);
    strobe(M_LDAR | M_LDI);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst = 1;
    prog_addr = '0;
    prog_data = '0;
    #1;
    do_reset();

    // Reset state
    expect_val("rst_pc", SIG_PC, 16'h0010);
    expect_val("rst_ar", SIG_AR, 16'h0000);
    expect_val("rst_ir", SIG_IR, 16'h0000);
    expect_val("rst_op", SIG_OP, 16'h0000);
    expect_val("rst_i",  SIG_I,  16'h0000);
    expect_err("rst_err", 1'b0);
    drain();

    // bus_q reset value observed through IR; also an IR load from an unwritten bus
    strobe(M_LDIR);
    expect_val("rst_bus_ir", SIG_IR, 16'h0000);
    expect_val("rst_bus_op", SIG_OP, 16'h0000);
    expect_err("unwritten_bus_err", 1'b1);
    drain();
    do_reset();
    expect_err("err_cleared", 1'b0);
    drain();

    // Walk PC from 0x010 to 0xFFF, then wrap
    for (int i = 0; i < 4079; i++) strobe(M_INR);
    expect_val("pc_fff", SIG_PC, 16'h0FFF);
    drain();
    strobe(M_INR);
    expect_val("pc_wrap", SIG_PC, 16'h0000);
    drain();

    // Direct fetch from PC=0
    prog(12'h000, 16'h2345);
    fetch_t0_t4();
    fetch_t5_t6();
    expect_val("dir_ir", SIG_IR, 16'h2345);
    expect_val("dir_op", SIG_OP, 16'h0002);
    expect_val("dir_i",  SIG_I,  16'h0000);
    expect_val("dir_ar", SIG_AR, 16'h0345);
    expect_val("dir_pc", SIG_PC, 16'h0001);
    expect_err("dir_err", 1'b0);
    drain();

    // Indirect fetch from PC=1
    prog(12'h001, 16'hA100);
    prog(12'h100, 16'h0777);
    fetch_t0_t4();
    fetch_t5_t6();
    strobe(M_RD);
    strobe(M_X7);
    strobe(M_LDAR);
    expect_val("ind_op", SIG_OP, 16'h0002);
    expect_val("ind_i",  SIG_I,  16'h0001);
    expect_val("ind_ar", SIG_AR, 16'h0777);
    expect_val("ind_pc", SIG_PC, 16'h0002);
    drain();

    // Bus priority: set up PC=5, IR=0x1234, DR=0xBEEF
    prog(12'h002, 16'h1234);
    prog(12'h003, 16'hBEEF);
    fetch_t0_t4();
    strobe(M_X2);
    strobe(M_LDAR);
    strobe(M_RD);
    strobe(M_INR);
    strobe(M_INR);
    expect_val("pri_setup_pc", SIG_PC, 16'h0005);
    expect_val("pri_setup_ir", SIG_IR, 16'h1234);
    expect_err("pri_setup_err", 1'b0);
    drain();
    strobe(M_X2 | M_X5);
    strobe(M_LDIR);
    expect_val("pri_x5_over_x2", SIG_IR, 16'h1234);
    expect_err("pri_two_sel_err", 1'b1);
    drain();
    strobe(M_X2 | M_X5 | M_X7);
    strobe(M_LDIR);
    expect_val("pri_x7_ir", SIG_IR, 16'hBEEF);
    expect_val("pri_x7_op", SIG_OP, 16'h0003);
    expect_err("pri_err", 1'b1);
    drain();

    // Read/write collision at AR=0
    do_reset();
    expect_val("rst2_pc", SIG_PC, 16'h0010);
    expect_err("rst2_err", 1'b0);
    drain();
    prog(12'h000, 16'h1111);
    prog_we   = 1;
    prog_addr = 12'h000;
    prog_data = 16'h5555;
    Read      = 1;
    @(posedge clk);
    #1;
    clr();
    strobe(M_X7);
    strobe(M_LDIR);
    expect_val("rbw_dr", SIG_IR, 16'h1111);
    drain();

    // Mid-fetch reset at T3, with strobes and a program write that must be ignored
    strobe(M_X2);
    strobe(M_LDAR);
    strobe(M_RD);
    rst       = 1;
    x7        = 1;
    ldIR      = 1;
    inrPC     = 1;
    prog_we   = 1;
    prog_addr = 12'h000;
    prog_data = 16'hDEAD;
    @(posedge clk);
    #1;
    clr();
    rst = 0;
    expect_val("mid_pc", SIG_PC, 16'h0010);
    expect_val("mid_ar", SIG_AR, 16'h0000);
    expect_val("mid_ir", SIG_IR, 16'h0000);
    expect_val("mid_op", SIG_OP, 16'h0000);
    expect_val("mid_i",  SIG_I,  16'h0000);
    expect_err("mid_err", 1'b0);
    drain();

    strobe(M_RD);
    strobe(M_X7);
    strobe(M_LDIR);
    expect_val("post_rd_ir", SIG_IR, 16'h5555);
    expect_val("post_rd_op", SIG_OP, 16'h0005);
    expect_err("post_rd_err", 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
